pll_lock_supervisor: RTL

PLL_LOCK_SUPERVISOR -- requirements
Module: pll_lock_supervisor

---
 rtl/pll_sup_pkg.sv | 27 ++
 rtl/pll_sup_sync.sv | 26 ++
 rtl/pll_lock_supervisor.sv | 119 +++++++++++
 3 files changed

// File: rtl/pll_sup_pkg.sv
// pll_sup_pkg -- shared definitions for the PLL lock supervisor.
//   pll_sup_state_t : supervisor FSM state encoding
//   *_DEF           : default values of the supervisor timing parameters
//   max3()          : helper used to size the shared state timer
// Optional feature macro used by the slice: PLL_SUP_STATUS_CNT_EN.
package pll_sup_pkg;

    localparam int unsigned RST_CYCLES_DEF    = 16;
    localparam int unsigned STABLE_CYCLES_DEF = 1024;
    localparam int unsigned LOCK_TIMEOUT_DEF  = 65536;

    typedef enum logic [1:0] {
        ST_PLL_RST   = 2'd0,
        ST_WAIT_LOCK = 2'd1,
        ST_STABLE    = 2'd2,
        ST_RUN       = 2'd3
    } pll_sup_state_t;

    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/pll_sup_sync.sv
// pll_sup_sync -- two-flop synchronizer for an asynchronous level input.
// Ports:
//   clk : destination clock
//   rst : asynchronous active-high reset, clears both stages to 0
//   d   : asynchronous input
//   q   : second-stage (synchronized) output
module pll_sup_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor -- sequences the PLL reset, waits for a stable lock and
// holds downstream logic in reset until the lock has been stable long enough.
// Ports:
//   refclk       : PLL reference clock, the only clock of this block
//   rst          : asynchronous active-high reset
//   pll_locked   : PLL lock indication, asynchronous to refclk
//   force_relock : single-cycle request to restart the PLL
//   pll_rst      : drives the PLL reset input
//   sys_reset    : active-high reset for logic clocked by the PLL outputs
//   lock_ok      : high only while the supervisor is in RUN
//   loss_cnt     : saturating count of lock losses seen in RUN
//   retry_cnt    : saturating count of lock timeouts
// Macro PLL_SUP_STATUS_CNT_EN enables the status counters; when undefined
// loss_cnt and retry_cnt read 0 and the FSM is unchanged.
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int unsigned RST_CYCLES    = RST_CYCLES_DEF,
    parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_DEF,
    parameter int unsigned LOCK_TIMEOUT  = LOCK_TIMEOUT_DEF,
    parameter int unsigned CNT_W         = 8
) (
    input  logic             refclk,
    input  logic             rst,
    input  logic             pll_locked,
    input  logic             force_relock,
    output logic             pll_rst,
    output logic             sys_reset,
    output logic             lock_ok,
    output logic [CNT_W-1:0] loss_cnt,
    output logic [CNT_W-1:0] retry_cnt
);

    // One timer is shared by all timed states; it clears on every state entry.
    localparam int unsigned TMR_W = $clog2(max3(RST_CYCLES, STABLE_CYCLES, LOCK_TIMEOUT) + 1);
    localparam logic [TMR_W-1:0] RST_LAST = TMR_W'(RST_CYCLES - 1);
    localparam logic [TMR_W-1:0] STB_LAST = TMR_W'(STABLE_CYCLES - 1);
    localparam logic [TMR_W-1:0] TO_LAST  = TMR_W'(LOCK_TIMEOUT - 1);

    pll_sup_state_t   state, state_nxt;
    logic [TMR_W-1:0] timer, timer_nxt;
    logic             lock_s;

    pll_sup_sync u_sync (
        .clk (refclk),
        .rst (rst),
        .d   (pll_locked),
        .q   (lock_s)
    );

    always_comb begin
        state_nxt = state;
        timer_nxt = timer + TMR_W'(1);
        unique case (state)
            ST_PLL_RST: begin
                if (timer == RST_LAST) state_nxt = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                if (lock_s)                 state_nxt = ST_STABLE;
                else if (timer == TO_LAST)  state_nxt = ST_PLL_RST;
            end
            ST_STABLE: begin
                if (!lock_s)                state_nxt = ST_WAIT_LOCK;
                else if (timer == STB_LAST) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                timer_nxt = '0;
                if (!lock_s) state_nxt = ST_WAIT_LOCK;
            end
            default: state_nxt = ST_PLL_RST;
        endcase
        if (force_relock) state_nxt = ST_PLL_RST;
        // A relock request inside PLL_RST is a re-entry: restart the pulse.
        if (state_nxt != state || force_relock) timer_nxt = '0;
    end

    // Outputs are registered from the next state so they change on the
    // same edge as the state itself.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state     <= ST_PLL_RST;
            timer     <= '0;
            pll_rst   <= 1'b1;
            sys_reset <= 1'b1;
            lock_ok   <= 1'b0;
        end else begin
            state     <= state_nxt;
            timer     <= timer_nxt;
            pll_rst   <= (state_nxt == ST_PLL_RST);
            sys_reset <= (state_nxt != ST_RUN);
            lock_ok   <= (state_nxt == ST_RUN);
        end
    end

`ifdef PLL_SUP_STATUS_CNT_EN
    logic loss_evt, retry_evt;

    // A lock loss in RUN is counted even when force_relock wins the transition.
    assign loss_evt  = (state == ST_RUN) && !lock_s;
    assign retry_evt = (state == ST_WAIT_LOCK) && !lock_s && !force_relock
                       && (timer == TO_LAST);

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            loss_cnt  <= '0;
            retry_cnt <= '0;
        end else begin
            if (loss_evt && (loss_cnt != '1))
                loss_cnt <= loss_cnt + CNT_W'(1);
            if (retry_evt && (retry_cnt != '1))
                retry_cnt <= retry_cnt + CNT_W'(1);
        end
    end
`else
    assign loss_cnt  = '0;
    assign retry_cnt = '0;
`endif

endmodule
